// File: rtl/rf_access_arbiter_if.sv
// Requester-side and RF-side signal bundle for rf_access_arbiter.
// slave: the arbiter's view. master: the requesters' and the RF's view.
interface rf_access_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 64
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_invalid;
    logic                      rsp_timeout;
    logic                      busy;
    logic [ADDR_W-1:0]         rf_address;
    logic [DATA_W-1:0]         rf_write_data;
    logic                      rf_read_en;
    logic                      rf_write_en;
    logic [DATA_W-1:0]         rf_read_data;
    logic                      rf_invalid_address;
    logic                      rf_access_complete;

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
        input  rf_read_data, rf_invalid_address, rf_access_complete,
        output req_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout, busy,
        output rf_address, rf_write_data, rf_read_en, rf_write_en
    );

    modport master (
        output req_valid, req_write, req_address, req_wdata,
        output rf_read_data, rf_invalid_address, rf_access_complete,
        input  req_ready, rsp_valid, rsp_rdata, rsp_invalid, rsp_timeout, busy,
        input  rf_address, rf_write_data, rf_read_en, rf_write_en
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter for single RF accesses from NUM_REQ requesters.
// One transaction in flight: IDLE (grant) -> ISSUE (strobe) -> WAIT
// (complete or timeout) -> RESP (one-cycle response strobe).
module rf_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input logic                clk_hmc,
    input logic                res_hmc,
    rf_access_arbiter_if.slave bus
);
    localparam int               PTR_W   = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ - 1);
    localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                         state;
    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               gnt_idx;
    logic [PTR_W-1:0]               gnt_q;
    logic                           gnt_any;
    logic                           accept;
    logic                           write_q;
    logic [7:0]                     wait_cnt;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;

    assign addr_a  = bus.req_address;
    assign wdata_a = bus.req_wdata;

    // First pending requester at or above rr_ptr, wrapping at NUM_REQ
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int               j;
            logic [PTR_W-1:0] cand;
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            cand = PTR_W'(j);
            if (!gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Acceptance is combinational in IDLE; held low while reset is asserted
    assign accept        = (state == IDLE) && gnt_any;
    assign bus.req_ready = (accept && !res_hmc) ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Transaction sequencer with registered strobes, status and response
    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            gnt_q             <= '0;
            write_q           <= 1'b0;
            wait_cnt          <= '0;
            bus.busy          <= 1'b0;
            bus.rf_address    <= '0;
            bus.rf_write_data <= '0;
            bus.rf_read_en    <= 1'b0;
            bus.rf_write_en   <= 1'b0;
            bus.rsp_valid     <= '0;
            bus.rsp_rdata     <= '0;
            bus.rsp_invalid   <= 1'b0;
            bus.rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        gnt_q             <= gnt_idx;
                        rr_ptr            <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                        write_q           <= bus.req_write[gnt_idx];
                        bus.rf_address    <= addr_a[gnt_idx];
                        bus.rf_write_data <= wdata_a[gnt_idx];
                        bus.rf_write_en   <= bus.req_write[gnt_idx];
                        bus.rf_read_en    <= !bus.req_write[gnt_idx];
                        bus.busy          <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.rf_write_en <= 1'b0;
                    bus.rf_read_en  <= 1'b0;
                    wait_cnt        <= '0;
                    state           <= WAIT;
                end
                WAIT: begin
                    if (bus.rf_access_complete) begin
                        bus.rsp_valid   <= NUM_REQ'(1) << gnt_q;
                        bus.rsp_invalid <= bus.rf_invalid_address;
                        bus.rsp_rdata   <= (!write_q && !bus.rf_invalid_address)
                                           ? bus.rf_read_data : '0;
                        state           <= RESP;
                    end else if (wait_cnt == TO_LAST) begin
                        bus.rsp_valid   <= NUM_REQ'(1) << gnt_q;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    bus.rsp_valid   <= '0;
                    bus.rsp_invalid <= 1'b0;
                    bus.rsp_timeout <= 1'b0;
                    bus.rsp_rdata   <= '0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: a transaction-level model predicts every
// output each cycle from "cycles since accept"; directed tests pin it with
// hand-computed literals.
module tb_rf_access_arbiter;
    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1   = 64'hFEDC_BA98_7654_3210;

    logic clk_hmc = 1'b0;
    logic res_hmc = 1'b1;
    always #5 clk_hmc = ~clk_hmc;

    rf_access_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_hmc (clk_hmc),
        .res_hmc (res_hmc),
        .bus     (bus)
    );

    int checks = 0, failures = 0, cyc = 0, we_cnt = 0, rsp_cnt = 0;
    int cpl_delay = 1;
    bit cpl_never = 0, cpl_invalid = 0, cpl_in_issue = 0;
    logic [DW-1:0] mem [16];

    always @(posedge clk_hmc) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // RF responder: completes cpl_delay cycles after the strobe cycle
    initial begin : rf_model
        int  r_t;
        bit  r_act, cpl;
        r_t = 0;
        r_act = 0;
        for (int i = 0; i < 16; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        bus.rf_access_complete = 1'b0;
        bus.rf_invalid_address = 1'b0;
        bus.rf_read_data       = '0;
        forever begin
            @(posedge clk_hmc);
            #1;
            if (res_hmc) begin
                r_act = 0;
                bus.rf_access_complete = 1'b0;
                bus.rf_invalid_address = 1'b0;
                continue;
            end
            if (bus.rf_write_en || bus.rf_read_en) begin
                r_t = 0;
                r_act = 1;
                if (bus.rf_write_en) mem[bus.rf_address] = bus.rf_write_data;
            end else if (r_act) begin
                r_t++;
            end
            cpl = r_act && ((r_t == 0 && cpl_in_issue) || (r_t == cpl_delay && !cpl_never));
            bus.rf_access_complete = cpl;
            bus.rf_invalid_address = cpl && cpl_invalid;
            bus.rf_read_data = cpl ? mem[bus.rf_address] : {$urandom, $urandom};
        end
    end

    // Behavioural model: t = cycles since the accept cycle; strobe at t=1,
    // wait cycles from t=2, response one cycle after complete or after TO waits
    initial begin : model
        bit            m_act, m_wr, m_inv, m_to, found;
        int            m_t, m_rt, m_g, m_rr, j, jg;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_rd;
        logic [N-1:0]  e_ready, e_rv;
        bit            e_rd, e_we, e_busy;
        m_act = 0; m_wr = 0; m_inv = 0; m_to = 0;
        m_t = 0; m_rt = 0; m_g = 0; m_rr = 0;
        m_addr = '0; m_wdata = '0; m_rd = '0;
        forever begin
            @(negedge clk_hmc);
            if (bus.rf_write_en) we_cnt++;
            if (bus.rsp_valid != '0) rsp_cnt++;
            if (res_hmc) begin
                chk("rst_ctrl_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_invalid,
                    bus.rsp_timeout, bus.busy, bus.rf_read_en, bus.rf_write_en}, 64'd0);
                chk("rst_rf_address", bus.rf_address, 64'd0);
                chk("rst_rf_write_data", bus.rf_write_data, 64'd0);
                chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
                m_act = 0; m_rr = 0; m_addr = '0; m_wdata = '0;
            end else begin
                e_ready = '0; e_rv = '0; e_rd = 0; e_we = 0; e_busy = 0;
                found = 0; jg = 0;
                if (!m_act) begin
                    for (int k = 0; k < N; k++) begin
                        j = (m_rr + k) % N;
                        if (!found && bus.req_valid[j]) begin
                            found = 1;
                            jg = j;
                        end
                    end
                    if (found) e_ready[jg] = 1'b1;
                end else begin
                    e_busy = 1;
                    if (m_t == 1) begin
                        e_we = m_wr;
                        e_rd = !m_wr;
                    end
                    if (m_t == m_rt) e_rv[m_g] = 1'b1;
                end
                chk("m_req_ready", bus.req_ready, e_ready);
                chk("m_rsp_valid", bus.rsp_valid, e_rv);
                chk("m_rsp_invalid", bus.rsp_invalid, (e_rv != 0) && m_inv);
                chk("m_rsp_timeout", bus.rsp_timeout, (e_rv != 0) && m_to);
                chk("m_busy", bus.busy, e_busy);
                chk("m_strobes", {bus.rf_read_en, bus.rf_write_en}, {e_rd, e_we});
                chk("m_rf_address", bus.rf_address, m_addr);
                chk("m_rf_write_data", bus.rf_write_data, m_wdata);
                if (e_rv != 0) chk("m_rsp_rdata", bus.rsp_rdata, m_rd);
                // advance to the next cycle
                if (!m_act) begin
                    if (found) begin
                        m_act = 1; m_t = 1; m_rt = 0; m_g = jg;
                        m_wr = bus.req_write[jg];
                        m_addr = bus.req_address[jg*AW +: AW];
                        m_wdata = bus.req_wdata[jg*DW +: DW];
                        m_rr = (jg + 1) % N;
                    end
                end else begin
                    if (m_rt == 0 && m_t >= 2) begin
                        if (bus.rf_access_complete) begin
                            m_rt = m_t + 1; m_to = 0; m_inv = bus.rf_invalid_address;
                            m_rd = (!m_wr && !m_inv) ? bus.rf_read_data : '0;
                        end else if (m_t - 1 == TO) begin
                            m_rt = m_t + 1; m_to = 1; m_inv = 0; m_rd = '0;
                        end
                    end
                    if (m_t == m_rt) m_act = 0;
                    else m_t++;
                end
            end
        end
    end

    task automatic set_req(input bit i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_write[i] = wr;
        bus.req_address[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    // One transaction from requester i; reports latency accept->rsp_valid
    task automatic txn(input string nm, input bit i, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd,
                       output logic inv, output logic to, output int lat);
        bit ok;
        int acc;
        @(posedge clk_hmc);
        #1;
        set_req(i, wr, a, d);
        bus.req_valid[i] = 1'b1;
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_hmc);
            if (bus.req_ready[i]) begin ok = 1; break; end
        end
        chk({nm, "_accept"}, 64'(ok), 64'd1);
        acc = cyc;
        @(posedge clk_hmc);
        #1;
        bus.req_valid[i] = 1'b0;
        ok = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk_hmc);
            if (bus.rsp_valid[i]) begin ok = 1; break; end
        end
        chk({nm, "_response"}, 64'(ok), 64'd1);
        lat = cyc - acc;
        rd = bus.rsp_rdata;
        inv = bus.rsp_invalid;
        to = bus.rsp_timeout;
    endtask

    initial begin : stim
        logic [DW-1:0] rd;
        logic          inv, to;
        logic [N-1:0]  exp_rv;
        int            lat, w0, r0, prev;
        bit            ok, g;
        bit            exp_g [4];
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_address = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk_hmc);
        #1;
        chk("reset_busy", bus.busy, 64'd0);
        chk("reset_rf_address", bus.rf_address, 64'd0);
        res_hmc = 1'b0;

        // write all-ones to address 2, then read it back
        w0 = we_cnt;
        txn("wr", 1'b0, 1'b1, 4'd2, ONES, rd, inv, to, lat);
        chk("wr_latency", 64'(lat), 64'd3);
        chk("wr_strobe_cycles", 64'(we_cnt - w0), 64'd1);
        chk("wr_status", {inv, to}, 64'd0);
        chk("wr_addr_held", bus.rf_address, 64'd2);
        chk("wr_data_held", bus.rf_write_data, ONES);
        txn("rd", 1'b0, 1'b0, 4'd2, '0, rd, inv, to, lat);
        chk("rd_data", rd, ONES);
        chk("rd_latency", 64'(lat), 64'd3);

        // RF never completes
        cpl_never = 1;
        txn("to", 1'b1, 1'b0, 4'd3, '0, rd, inv, to, lat);
        cpl_never = 0;
        chk("to_latency", 64'(lat), 64'd18);
        chk("to_flags", {inv, to}, 64'd1);
        chk("to_rdata", rd, 64'd0);

        // contention: both requesters held valid, four back-to-back grants
        @(posedge clk_hmc);
        #1;
        set_req(1'b0, 1'b1, 4'd4, D0);
        set_req(1'b1, 1'b0, 4'd4, '0);
        bus.req_valid = 2'b11;
        prev = 0;
        for (int t = 0; t < 4; t++) begin
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk_hmc);
                if (bus.req_ready != '0) begin ok = 1; break; end
            end
            chk("cont_accept", 64'(ok), 64'd1);
            g = bus.req_ready[1];
            chk("cont_grant", 64'(g), 64'(exp_g[t]));
            if (t > 0) chk("cont_spacing", 64'(cyc - prev), 64'd4);
            prev = cyc;
            @(posedge clk_hmc);
            #1;
            if (t >= 2) bus.req_valid[g] = 1'b0;
            else if (!g) set_req(1'b0, 1'b1, 4'd4, D1);
            ok = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk_hmc);
                if (bus.rsp_valid != '0) begin ok = 1; break; end
            end
            chk("cont_response", 64'(ok), 64'd1);
            exp_rv = 2'b01 << g;
            chk("cont_rsp_target", bus.rsp_valid, exp_rv);
            if (t == 1) chk("cont_rdata1", bus.rsp_rdata, D0);
            if (t == 3) chk("cont_rdata3", bus.rsp_rdata, D1);
        end

        // invalid address
        cpl_invalid = 1;
        txn("inv", 1'b0, 1'b0, 4'd15, '0, rd, inv, to, lat);
        cpl_invalid = 0;
        chk("inv_flags", {inv, to}, 64'd2);
        chk("inv_rdata", rd, 64'd0);

        // complete during ISSUE is ignored; the later one is used
        cpl_in_issue = 1;
        cpl_delay = 3;
        txn("late", 1'b1, 1'b0, 4'd2, '0, rd, inv, to, lat);
        cpl_in_issue = 0;
        cpl_delay = 1;
        chk("late_latency", 64'(lat), 64'd5);
        chk("late_rdata", rd, ONES);

        // reset three cycles after a read strobe (in WAIT)
        cpl_never = 1;
        @(posedge clk_hmc);
        #1;
        set_req(1'b0, 1'b0, 4'd5, '0);
        bus.req_valid[0] = 1'b1;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_hmc);
            if (bus.req_ready[0]) begin ok = 1; break; end
        end
        chk("rst_accept", 64'(ok), 64'd1);
        @(posedge clk_hmc);
        #1;
        bus.req_valid[0] = 1'b0;
        repeat (3) @(posedge clk_hmc);
        #1;
        r0 = rsp_cnt;
        res_hmc = 1'b1;
        #1;
        chk("async_busy", bus.busy, 64'd0);
        chk("async_rf_address", bus.rf_address, 64'd0);
        repeat (2) @(posedge clk_hmc);
        #1;
        res_hmc = 1'b0;
        cpl_never = 0;
        repeat (4) @(posedge clk_hmc);
        #1;
        chk("rst_dropped_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        set_req(1'b0, 1'b0, 4'd2, '0);
        set_req(1'b1, 1'b0, 4'd2, '0);
        bus.req_valid = 2'b11;
        @(negedge clk_hmc);
        chk("post_rst_grant", bus.req_ready, 64'd1);
        @(posedge clk_hmc);
        #1;
        bus.req_valid[0] = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_hmc);
            if (bus.req_ready[1]) begin ok = 1; break; end
        end
        chk("post_rst_req1", 64'(ok), 64'd1);
        @(posedge clk_hmc);
        #1;
        bus.req_valid[1] = 1'b0;
        repeat (8) @(posedge clk_hmc);
        #1;
        chk("post_rst_rsp_count", 64'(rsp_cnt - r0), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
